// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame field encoding and data-width limits
//
// Purpose: common types and constants for the UART frame sequencer and the
//          RX checker that reuses the frame-length calculator.
// Contents:
//   uart_field_e        field currently being sequenced (IDLE..STOP)
//   UART_MIN_DATA_BITS  smallest legal data width
//   UART_MAX_DATA_BITS  default largest legal data width
package uart_pkg;

    typedef enum logic [2:0] {
        FIELD_IDLE   = 3'd0,
        FIELD_START  = 3'd1,
        FIELD_DATA   = 3'd2,
        FIELD_PARITY = 3'd3,
        FIELD_STOP   = 3'd4
    } uart_field_e;

    localparam int UART_MIN_DATA_BITS = 5;
    localparam int UART_MAX_DATA_BITS = 9;

endpackage : uart_pkg

// File: rtl/uart_frame_len.sv
// rtl/uart_frame_len.sv - combinational UART frame length and config legality
//
// Purpose: L = start + D data + P parity + S stop bits, and whether D is legal.
// Ports:
//   data_bits_i   in  4      requested data bit count D
//   parity_en_i   in  1      parity bit present
//   stop2_i       in  1      two stop bits when set
//   frame_len_o   out CNT_W  total frame length in bit periods
//   legal_o       out 1      MIN <= D <= MAX_DATA_BITS
module uart_frame_len
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = UART_MAX_DATA_BITS,
    parameter int CNT_W         = $clog2(MAX_DATA_BITS + 5)
) (
    input  logic [3:0]       data_bits_i,
    input  logic             parity_en_i,
    input  logic             stop2_i,
    output logic [CNT_W-1:0] frame_len_o,
    output logic             legal_o
);

    localparam logic [3:0] MIN_D = 4'(UART_MIN_DATA_BITS);
    localparam logic [3:0] MAX_D = 4'(MAX_DATA_BITS);

    logic [CNT_W-1:0] w_data_bits;
    logic [CNT_W-1:0] w_parity;
    logic [CNT_W-1:0] w_stop2;

    assign w_data_bits = CNT_W'(data_bits_i);
    assign w_parity    = CNT_W'(parity_en_i);
    assign w_stop2     = CNT_W'(stop2_i);

    // The constant 2 is the start bit plus the mandatory first stop bit.
    // Illegal D may wrap, but such a length is never latched.
    assign frame_len_o = w_data_bits + w_parity + w_stop2 + CNT_W'(2);
    assign legal_o     = (data_bits_i >= MIN_D) && (data_bits_i <= MAX_D);

endmodule : uart_frame_len

// File: rtl/uart_frame_counter.sv
// rtl/uart_frame_counter.sv - UART frame sequencer counting bit periods per field
//
// Purpose: walks START, DATA, optional PARITY and 1/2 STOP bits, one bit per
//          tick_i, with configuration latched when a frame is accepted.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   start_i            request a frame (IDLE only)
//   tick_i             end of one bit period
//   abort_i            abandon the frame; beats tick_i and start_i
//   data_bits_i        D, sampled with start_i
//   parity_en_i        P, sampled with start_i
//   stop2_i            second stop bit, sampled with start_i
//   busy_o             frame in progress
//   field_o            current field (uart_field_e)
//   bit_idx_o          index within DATA or STOP, 0 elsewhere
//   count_o            bit periods completed in this frame
//   frame_len_o        latched frame length L
//   done_o             one-cycle pulse on normal completion
//   cfg_err_o          one-cycle pulse when a start is rejected
module uart_frame_counter
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = UART_MAX_DATA_BITS,
    parameter int CNT_W         = $clog2(MAX_DATA_BITS + 5)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             tick_i,
    input  logic             abort_i,
    input  logic [3:0]       data_bits_i,
    input  logic             parity_en_i,
    input  logic             stop2_i,
    output logic             busy_o,
    output logic [2:0]       field_o,
    output logic [3:0]       bit_idx_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] frame_len_o,
    output logic             done_o,
    output logic             cfg_err_o
);

    uart_field_e      r_state;
    uart_field_e      w_state;
    logic             r_busy;
    logic [3:0]       r_bit_idx;
    logic [3:0]       w_bit_idx;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_inc;
    logic [CNT_W-1:0] r_frame_len;
    logic [3:0]       r_data_bits;
    logic             r_parity_en;
    logic             r_done;
    logic             w_done;
    logic             r_cfg_err;
    logic             w_cfg_err;
    logic             w_load;
    logic [CNT_W-1:0] w_len;
    logic             w_legal;

    uart_frame_len #(
        .MAX_DATA_BITS (MAX_DATA_BITS),
        .CNT_W         (CNT_W)
    ) u_frame_len (
        .data_bits_i (data_bits_i),
        .parity_en_i (parity_en_i),
        .stop2_i     (stop2_i),
        .frame_len_o (w_len),
        .legal_o     (w_legal)
    );

    assign w_count_inc = r_count + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= FIELD_IDLE;
            r_busy      <= 1'b0;
            r_bit_idx   <= 4'd0;
            r_count     <= '0;
            r_frame_len <= '0;
            r_data_bits <= 4'd0;
            r_parity_en <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_busy    <= (w_state != FIELD_IDLE);
            r_bit_idx <= w_bit_idx;
            r_count   <= w_count;
            r_done    <= w_done;
            r_cfg_err <= w_cfg_err;
            if (w_load) begin
                r_frame_len <= w_len;
                r_data_bits <= data_bits_i;
                r_parity_en <= parity_en_i;
            end
        end
    end

    always_comb begin
        w_state   = r_state;
        w_bit_idx = r_bit_idx;
        w_count   = r_count;
        w_done    = 1'b0;
        w_cfg_err = 1'b0;
        w_load    = 1'b0;

        if (abort_i) begin
            w_state   = FIELD_IDLE;
            w_bit_idx = 4'd0;
            w_count   = '0;
        end else begin
            case (r_state)
                FIELD_IDLE: begin
                    // A tick arriving with the start is not part of the new frame.
                    if (start_i) begin
                        if (w_legal) begin
                            w_load    = 1'b1;
                            w_state   = FIELD_START;
                            w_bit_idx = 4'd0;
                            w_count   = '0;
                        end else begin
                            w_cfg_err = 1'b1;
                        end
                    end
                end
                FIELD_START: begin
                    if (tick_i) begin
                        w_count   = w_count_inc;
                        w_state   = FIELD_DATA;
                        w_bit_idx = 4'd0;
                    end
                end
                FIELD_DATA: begin
                    if (tick_i) begin
                        w_count = w_count_inc;
                        if (r_bit_idx == r_data_bits - 4'd1) begin
                            w_state   = r_parity_en ? FIELD_PARITY : FIELD_STOP;
                            w_bit_idx = 4'd0;
                        end else begin
                            w_bit_idx = r_bit_idx + 4'd1;
                        end
                    end
                end
                FIELD_PARITY: begin
                    if (tick_i) begin
                        w_count   = w_count_inc;
                        w_state   = FIELD_STOP;
                        w_bit_idx = 4'd0;
                    end
                end
                FIELD_STOP: begin
                    if (tick_i) begin
                        w_count = w_count_inc;
                        // Frame ends on the tick that brings the count to L,
                        // which covers both the 1- and 2-stop-bit cases.
                        if (w_count_inc == r_frame_len) begin
                            w_state   = FIELD_IDLE;
                            w_bit_idx = 4'd0;
                            w_done    = 1'b1;
                        end else begin
                            w_bit_idx = r_bit_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    w_state   = FIELD_IDLE;
                    w_bit_idx = 4'd0;
                    w_count   = '0;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign field_o     = r_state;
    assign bit_idx_o   = r_bit_idx;
    assign count_o     = r_count;
    assign frame_len_o = r_frame_len;
    assign done_o      = r_done;
    assign cfg_err_o   = r_cfg_err;

endmodule : uart_frame_counter

// File: tb/tb_uart_frame_counter.sv
// tb/tb_uart_frame_counter.sv - randomized self-checking bench for uart_frame_counter
module tb_uart_frame_counter;

    localparam int MAX_D = 9;
    localparam int CW    = $clog2(MAX_D + 5);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          tick;
    logic          abort;
    logic [3:0]    data_bits;
    logic          parity_en;
    logic          stop2;
    logic          busy;
    logic [2:0]    field;
    logic [3:0]    bit_idx;
    logic [CW-1:0] count;
    logic [CW-1:0] frame_len;
    logic          done;
    logic          cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame described by ticks taken k out of length L.
    bit m_active;
    int m_k;
    int m_len;
    int m_d;
    int m_p;
    int m_count;
    int m_flen;
    bit m_done;
    bit m_err;

    always #5 clk = ~clk;

    uart_frame_counter #(
        .MAX_DATA_BITS (MAX_D),
        .CNT_W         (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .tick_i      (tick),
        .abort_i     (abort),
        .data_bits_i (data_bits),
        .parity_en_i (parity_en),
        .stop2_i     (stop2),
        .busy_o      (busy),
        .field_o     (field),
        .bit_idx_o   (bit_idx),
        .count_o     (count),
        .frame_len_o (frame_len),
        .done_o      (done),
        .cfg_err_o   (cfg_err)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Field and index for a frame that has taken k ticks (k < L).
    function automatic void exp_pos(input int k, output int f, output int idx);
        if (k == 0) begin
            f = 1; idx = 0;
        end else if (k <= m_d) begin
            f = 2; idx = k - 1;
        end else if (m_p != 0 && k == m_d + 1) begin
            f = 3; idx = 0;
        end else begin
            f = 4; idx = k - 1 - m_d - m_p;
        end
    endfunction

    task automatic model_step();
        int d;
        d = int'(data_bits);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0; m_k = 0; m_count = 0; m_flen = 0;
        end else if (abort) begin
            m_active = 1'b0; m_count = 0;
        end else if (!m_active) begin
            if (start) begin
                if (d >= 5 && d <= MAX_D) begin
                    m_active = 1'b1;
                    m_k      = 0;
                    m_count  = 0;
                    m_d      = d;
                    m_p      = int'(parity_en);
                    m_len    = 2 + d + m_p + int'(stop2);
                    m_flen   = m_len;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (tick) begin
            m_k++;
            m_count = m_k;
            if (m_k == m_len) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        int f;
        int idx;
        if (m_active) exp_pos(m_k, f, idx);
        else begin
            f = 0; idx = 0;
        end
        check("busy",      int'(busy),      int'(m_active));
        check("field",     int'(field),     f);
        check("bit_idx",   int'(bit_idx),   idx);
        check("count",     int'(count),     m_count);
        check("frame_len", int'(frame_len), m_flen);
        check("done",      int'(done),      int'(m_done));
        check("cfg_err",   int'(cfg_err),   int'(m_err));
    endtask

    task automatic cycle(input logic st, input logic tk, input logic ab, input logic rn,
                         input logic [3:0] d, input logic p, input logic s2);
        @(negedge clk);
        start = st; tick = tk; abort = ab; rst_n = rn;
        data_bits = d; parity_en = p; stop2 = s2;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Accept a frame, then tick every gap cycles until it completes.
    task automatic run_frame(input logic [3:0] d, input logic p, input logic s2, input int gap);
        int n;
        n = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, d, p, s2);
        while (m_active && n < 400) begin
            cycle(1'b0, (n % gap) == gap - 1, 1'b0, 1'b1, 4'($urandom), 1'($urandom), 1'($urandom));
            n++;
        end
        check("frame_end_busy", int'(busy), 0);
    endtask

    initial begin
        start = 0; tick = 0; abort = 0; rst_n = 0;
        data_bits = 0; parity_en = 0; stop2 = 0;
        m_active = 0; m_k = 0; m_len = 0; m_d = 0; m_p = 0;
        m_count = 0; m_flen = 0; m_done = 0; m_err = 0;

        cycle(0, 0, 0, 0, 4'd0, 0, 0);
        cycle(1, 1, 0, 0, 4'd8, 0, 0);

        // 8N1, slow ticks
        run_frame(4'd8, 1'b0, 1'b0, 4);
        check("t1_len", int'(frame_len), 10);
        check("t1_count", int'(count), 10);

        // 9 data, parity, 2 stop, back-to-back with the done cycle
        run_frame(4'd9, 1'b1, 1'b1, 1);
        check("t2_len", int'(frame_len), 13);

        // illegal configs
        cycle(0, 0, 0, 1, 4'd0, 0, 0);
        cycle(1, 0, 0, 1, 4'd4, 0, 0);
        check("cfg4_busy", int'(busy), 0);
        cycle(1, 0, 0, 1, 4'd10, 0, 0);
        check("cfg10_err", int'(cfg_err), 1);

        // abort at data bit 3
        cycle(1, 0, 0, 1, 4'd8, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, 4'd0, 0, 0);
        check("ab_idx3", int'(bit_idx), 3);
        cycle(0, 1, 1, 1, 4'd0, 0, 0);
        check("ab_count", int'(count), 0);

        // abort with the final stop tick
        cycle(1, 0, 0, 1, 4'd5, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 1, 4'd0, 0, 0);
        cycle(0, 1, 1, 1, 4'd0, 0, 0);
        check("ab_last_done", int'(done), 0);

        // back-to-back into D=5 P=0 (L=7), mid-frame start ignored
        run_frame(4'd8, 1'b0, 1'b0, 1);
        cycle(1, 0, 0, 1, 4'd5, 0, 0);
        check("b2b_len", int'(frame_len), 7);
        cycle(0, 1, 0, 1, 4'd0, 0, 0);
        cycle(1, 1, 0, 1, 4'd9, 1, 1);
        check("mid_start_len", int'(frame_len), 7);

        // reset mid-DATA
        cycle(0, 1, 0, 0, 4'd0, 0, 0);
        check("rst_len", int'(frame_len), 0);

        // start+tick in IDLE
        cycle(1, 1, 0, 1, 4'd6, 0, 1);
        check("st_tick_count", int'(count), 0);

        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            logic st;
            st = m_active ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
            cycle(st,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 79) == 0,
                  $urandom_range(0, 399) != 0,
                  4'($urandom_range(3, 11)),
                  1'($urandom),
                  1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_frame_counter
